// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated
// rep+1 times with an optional idle gap between frames.
module sequence_generator #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [CNT_W-1:0] rep_in,
   input  logic [CNT_W-1:0] gap_in,
   input  logic             start_valid,
   output logic             start_ready,
   output logic             out,
   output logic             out_valid,
   output logic             frame_start,
   output logic             done,
   output logic             busy
);

   // state | meaning
   // IDLE  | waiting for a start handshake
   // SEND  | a pattern bit is on out every cycle
   // GAP   | idle cycles between consecutive frames
   // DONE  | one-cycle done pulse after the last bit
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   localparam int BW = $clog2(PAT_W);

   state_t           state, state_nx;
   logic [PAT_W-1:0] pat_lat, pat_lat_nx;
   logic [PAT_W-1:0] shreg, shreg_nx;
   logic [BW-1:0]    bit_cnt, bit_cnt_nx;
   logic [CNT_W-1:0] frame_cnt, frame_cnt_nx;
   logic [CNT_W-1:0] gap_lat, gap_lat_nx;
   logic [CNT_W-1:0] gap_cnt, gap_cnt_nx;
   logic             out_nx, out_valid_nx, frame_start_nx, done_nx;

   assign start_ready = (state == IDLE) && rst;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pat_lat     <= '0;
         shreg       <= '0;
         bit_cnt     <= '0;
         frame_cnt   <= '0;
         gap_lat     <= '0;
         gap_cnt     <= '0;
         out         <= 1'b0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nx;
         pat_lat     <= pat_lat_nx;
         shreg       <= shreg_nx;
         bit_cnt     <= bit_cnt_nx;
         frame_cnt   <= frame_cnt_nx;
         gap_lat     <= gap_lat_nx;
         gap_cnt     <= gap_cnt_nx;
         out         <= out_nx;
         out_valid   <= out_valid_nx;
         frame_start <= frame_start_nx;
         done        <= done_nx;
      end
   end

   // Outputs are computed one cycle ahead so they leave the block from flops.
   always_comb begin
      state_nx       = state;
      pat_lat_nx     = pat_lat;
      shreg_nx       = shreg;
      bit_cnt_nx     = bit_cnt;
      frame_cnt_nx   = frame_cnt;
      gap_lat_nx     = gap_lat;
      gap_cnt_nx     = gap_cnt;
      out_nx         = 1'b0;
      out_valid_nx   = 1'b0;
      frame_start_nx = 1'b0;
      done_nx        = 1'b0;

      case (state)
         IDLE: begin
            if (start_valid && start_ready) begin
               pat_lat_nx     = pat_in;
               frame_cnt_nx   = rep_in;
               gap_lat_nx     = gap_in;
               shreg_nx       = {pat_in[PAT_W-2:0], 1'b0};
               bit_cnt_nx     = BW'(PAT_W - 1);
               out_nx         = pat_in[PAT_W-1];
               out_valid_nx   = 1'b1;
               frame_start_nx = 1'b1;
               state_nx       = SEND;
            end
         end
         SEND: begin
            if (bit_cnt != '0) begin
               out_nx       = shreg[PAT_W-1];
               out_valid_nx = 1'b1;
               shreg_nx     = {shreg[PAT_W-2:0], 1'b0};
               bit_cnt_nx   = bit_cnt - BW'(1);
            end else if (frame_cnt != '0) begin
               frame_cnt_nx = frame_cnt - CNT_W'(1);
               if (gap_lat == '0) begin
                  shreg_nx       = {pat_lat[PAT_W-2:0], 1'b0};
                  bit_cnt_nx     = BW'(PAT_W - 1);
                  out_nx         = pat_lat[PAT_W-1];
                  out_valid_nx   = 1'b1;
                  frame_start_nx = 1'b1;
               end else begin
                  gap_cnt_nx = gap_lat;
                  state_nx   = GAP;
               end
            end else begin
               done_nx  = 1'b1;
               state_nx = DONE;
            end
         end
         GAP: begin
            if (gap_cnt == CNT_W'(1)) begin
               shreg_nx       = {pat_lat[PAT_W-2:0], 1'b0};
               bit_cnt_nx     = BW'(PAT_W - 1);
               out_nx         = pat_lat[PAT_W-1];
               out_valid_nx   = 1'b1;
               frame_start_nx = 1'b1;
               state_nx       = SEND;
            end else begin
               gap_cnt_nx = gap_cnt - CNT_W'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: per-cycle output traces packed into
// bit vectors (bit c = cycle c after acceptance) and compared to hand values.
module tb_sequence_generator;

   logic       clk;
   logic       rst;
   logic [3:0] pat_in;
   logic [3:0] rep_in;
   logic [3:0] gap_in;
   logic       start_valid;
   logic       start_ready;
   logic       out;
   logic       out_valid;
   logic       frame_start;
   logic       done;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] v_out, v_val, v_fs, v_done, v_busy, v_rdy;

   sequence_generator #(.PAT_W(4), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .pat_in      (pat_in),
      .rep_in      (rep_in),
      .gap_in      (gap_in),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .out         (out),
      .out_valid   (out_valid),
      .frame_start (frame_start),
      .done        (done),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Starts a transfer and records cycles 1..n. Optional mid-transfer
   // start pulse with a changed pattern (poke_c) and reset pulse (rst_c).
   task automatic run_xfer(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] gap,
                           input int n, input int poke_c, input int rst_c, input bit hold);
      pat_in = pat;
      rep_in = rep;
      gap_in = gap;
      start_valid = 1'b1;
      v_out = '0; v_val = '0; v_fs = '0; v_done = '0; v_busy = '0; v_rdy = '0;
      @(negedge clk);
      if (!hold) start_valid = 1'b0;
      for (int c = 1; c <= n; c++) begin
         v_out[c]  = out;
         v_val[c]  = out_valid;
         v_fs[c]   = frame_start;
         v_done[c] = done;
         v_busy[c] = busy;
         v_rdy[c]  = start_ready;
         if (c == poke_c) begin
            start_valid = 1'b1;
            pat_in      = 4'b0000;
         end else if (c == poke_c + 1) begin
            start_valid = 1'b0;
            pat_in      = pat;
         end
         if (c == rst_c) rst = 1'b0;
         else if (c == rst_c + 1) rst = 1'b1;
         if (c == n) start_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic check_trace(input string name, input logic [31:0] e_out, input logic [31:0] e_val,
                              input logic [31:0] e_fs, input logic [31:0] e_done,
                              input logic [31:0] e_busy, input logic [31:0] e_rdy);
      check({name, ".out"},         v_out,  e_out);
      check({name, ".out_valid"},   v_val,  e_val);
      check({name, ".frame_start"}, v_fs,   e_fs);
      check({name, ".done"},        v_done, e_done);
      check({name, ".busy"},        v_busy, e_busy);
      check({name, ".start_ready"}, v_rdy,  e_rdy);
   endtask

   int cnt_busy, cnt_val, cnt_fs, cnt_done, cnt_ones;

   initial begin
      rst = 1'b0;
      start_valid = 1'b1;
      pat_in = 4'b1101;
      rep_in = 4'd0;
      gap_in = 4'd0;

      // Reset held with start requested: nothing may be accepted.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst.outs", {28'd0, out, out_valid, frame_start, done}, 32'd0);
         check("rst.busy_ready", {30'd0, busy, start_ready}, 32'd0);
      end
      start_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst.release_ready", {31'd0, start_ready}, 32'd1);
      check("rst.release_busy", {31'd0, busy}, 32'd0);

      run_xfer(4'b1101, 4'd0, 4'd0, 6, -10, -10, 1'b0);
      check_trace("single", 32'h16, 32'h1E, 32'h2, 32'h20, 32'h3E, 32'h40);

      run_xfer(4'b1101, 4'd1, 4'd0, 10, -10, -10, 1'b0);
      check_trace("b2b", 32'h176, 32'h1FE, 32'h22, 32'h200, 32'h3FE, 32'h400);

      run_xfer(4'b1011, 4'd2, 4'd3, 20, -10, -10, 1'b0);
      check_trace("gap", 32'h68D1A, 32'h78F1E, 32'h8102, 32'h80000, 32'hFFFFE, 32'h100000);

      run_xfer(4'b1101, 4'd3, 4'd0, 20, 2, -10, 1'b0);
      check_trace("ignore", 32'h17776, 32'h1FFFE, 32'h2222, 32'h20000, 32'h3FFFE, 32'h1C0000);

      run_xfer(4'b1101, 4'd3, 4'd0, 12, -10, 6, 1'b0);
      check_trace("abort", 32'h76, 32'h7E, 32'h22, 32'h0, 32'h7E, 32'h1F00);

      run_xfer(4'b1101, 4'd0, 4'd0, 18, -10, -10, 1'b1);
      check_trace("cont", 32'h16596, 32'h1E79E, 32'h2082, 32'h20820, 32'h3EFBE, 32'h41040);

      // Maximum repeat and gap: 16 frames, 15 gaps of 15 cycles.
      pat_in = 4'b1001;
      rep_in = 4'd15;
      gap_in = 4'd15;
      start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      cnt_busy = 0; cnt_val = 0; cnt_fs = 0; cnt_done = 0; cnt_ones = 0;
      for (int c = 0; c < 320; c++) begin
         if (busy) cnt_busy++;
         if (out_valid) cnt_val++;
         if (frame_start) cnt_fs++;
         if (done) cnt_done++;
         if (out) cnt_ones++;
         @(negedge clk);
      end
      check("max.busy_cycles", cnt_busy, 32'd290);
      check("max.valid_cycles", cnt_val, 32'd64);
      check("max.frame_starts", cnt_fs, 32'd16);
      check("max.done_pulses", cnt_done, 32'd1);
      check("max.one_bits", cnt_ones, 32'd32);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
